ir_fetch: RTL and testbench

IR_FETCH -- requirements
Module: ir_fetch

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_wait_timer.sv | 28 ++
 rtl/ir_fetch.sv | 138 +++++++++++++
 tb/tb_ir_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, opcode constants, reset/timeout word.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LATCH = 3'd3,
        ST_HOLD  = 3'd4
    } fetch_state_t;

    localparam logic [3:0]  OP_JMP   = 4'h8;
    localparam logic [3:0]  OP_JZE   = 4'h9;
    localparam logic [3:0]  OP_JNE   = 4'hA;
    localparam logic [3:0]  OP_JCY   = 4'hB;
    localparam logic [3:0]  OP_BSR   = 4'hE;
    localparam logic [15:0] NOP_WORD = 16'h0000;

    // Conditional jumps need a second PC evaluation cycle.
    function automatic logic is_cond_jump(input logic [3:0] op);
        return (op == OP_JZE) || (op == OP_JNE) || (op == OP_JCY);
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Memory wait-cycle counter with limit compare used for fetch timeouts.
module fetch_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       count,
    input  logic [3:0] limit,
    output logic       expired
);

    logic [3:0] r_cnt;

    // Counter: cleared outside waits, advances once per waiting cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (clear) begin
            r_cnt <= 4'd0;
        end else if (count) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign expired = (r_cnt == limit);

endmodule

// File: rtl/ir_fetch.sv
// Instruction fetch stage: reads program memory at PC, loads IR, and
// strobes the PC stage (twice for conditional jumps). Timeouts load a NOP
// and raise a sticky fault while fetching carries on.
module ir_fetch #(
    parameter int unsigned WAIT_MAX = 15,
    parameter logic [15:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] PC,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_ack,
    output logic [15:0] IR,
    output logic        ir_valid,
    output logic        pc_en,
    output logic        busy,
    output logic        fault
);

    import cpu_pkg::*;

    localparam logic [3:0] LP_LIMIT = WAIT_MAX[3:0];

    fetch_state_t r_state;
    logic [15:0]  r_ir;
    logic [11:0]  r_addr;
    logic         r_rd;
    logic         r_valid;
    logic         r_pc_en;
    logic         r_busy;
    logic         r_fault;

    logic         w_count;
    logic         w_clear;
    logic         w_expired;

    // The counter runs while a request is outstanding without an ack; it
    // reads 1 in the first WAIT cycle, so it equals the WAIT cycle number.
    assign w_count = ((r_state == ST_REQ) && !mem_ack) ||
                     ((r_state == ST_WAIT) && !mem_ack && !w_expired);
    assign w_clear = !w_count;

    fetch_wait_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .count   (w_count),
        .limit   (LP_LIMIT),
        .expired (w_expired)
    );

    // Fetch FSM with all outputs registered; ack is checked before timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ir    <= NOP_WORD;
            r_addr  <= 12'h000;
            r_rd    <= 1'b0;
            r_valid <= 1'b0;
            r_pc_en <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_pc_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_addr  <= PC;
                        r_rd    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_REQ;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (mem_ack) begin
                        r_ir    <= mem_data;
                        r_rd    <= 1'b0;
                        r_valid <= 1'b1;
                        r_pc_en <= 1'b1;
                        r_state <= ST_LATCH;
                    end else if ((r_state == ST_WAIT) && w_expired) begin
                        r_ir    <= NOP_WORD;
                        r_fault <= 1'b1;
                        r_rd    <= 1'b0;
                        r_valid <= 1'b1;
                        r_pc_en <= 1'b1;
                        r_state <= ST_LATCH;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_LATCH: begin
                    if (is_cond_jump(r_ir[15:12])) begin
                        r_pc_en <= 1'b1;
                        r_state <= ST_HOLD;
                    end else if (en) begin
                        r_addr  <= PC;
                        r_rd    <= 1'b1;
                        r_state <= ST_REQ;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (en) begin
                        r_addr  <= PC;
                        r_rd    <= 1'b1;
                        r_state <= ST_REQ;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_rd    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr = r_addr;
    assign mem_rd   = r_rd;
    assign IR       = r_ir;
    assign ir_valid = r_valid;
    assign pc_en    = r_pc_en;
    assign busy     = r_busy;
    assign fault    = r_fault;

endmodule

// File: tb/tb_ir_fetch.sv
// Scoreboard bench for ir_fetch: a memory responder serves queued replies,
// a monitor checks every IR update against expected entries.
module tb_ir_fetch;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] PC;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic [15:0] IR;
    logic        ir_valid;
    logic        pc_en;
    logic        busy;
    logic        fault;

    typedef struct {
        logic [15:0] data;
        int          waits;
    } mem_rsp_t;

    typedef struct {
        logic [15:0] ir;
        logic [11:0] addr;
        logic        flt;
    } exp_t;

    mem_rsp_t mq[$];
    exp_t     sb[$];

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;
    int last_len = 0;
    bit addr_bad = 0;

    ir_fetch #(.WAIT_MAX(15), .NOP_WORD(16'h0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .PC       (PC),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .mem_ack  (mem_ack),
        .IR       (IR),
        .ir_valid (ir_valid),
        .pc_en    (pc_en),
        .busy     (busy),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [15:0] d, input int w,
                                input logic [15:0] ir, input logic [11:0] a, input logic f);
        mem_rsp_t r;
        exp_t     e;
        r.data = d;  r.waits = w;
        e.ir = ir;   e.addr = a;  e.flt = f;
        mq.push_back(r);
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int bound, output int lat);
        lat = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (ir_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk("ir_valid_timeout", 32'd0, 32'd1);
    endtask

    // Memory responder: serves one queued reply per request, acks after 'waits' cycles.
    initial begin
        int       cnt;
        mem_rsp_t cur;
        logic [11:0] a0;
        cnt = 0;
        a0 = 12'h000;
        cur.data = 16'h0000;
        cur.waits = 0;
        mem_ack = 1'b0;
        mem_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                if (cnt == 0) begin
                    if (mq.size() > 0) cur = mq.pop_front();
                    else begin cur.data = 16'h0000; cur.waits = 0; end
                    a0 = mem_addr;
                end else if (mem_addr !== a0) begin
                    addr_bad = 1'b1;
                end
                mem_ack  = (cnt == cur.waits);
                mem_data = mem_ack ? cur.data : 16'hDEAD;
                cnt++;
            end else begin
                if (cnt != 0) last_len = cnt;
                cnt = 0;
                mem_ack = 1'b0;
                mem_data = 16'hDEAD;
            end
        end
    end

    // Monitor: every ir_valid pulse must match the oldest expected fetch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && ir_valid === 1'b1) begin
                valid_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_ir_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_ir", IR, e.ir);
                    chk("sb_addr", mem_addr, e.addr);
                    chk("sb_fault", fault, e.flt);
                end
            end
        end
    end

    initial begin
        int lat;
        int vc0;
        rst = 1'b1;
        en  = 1'b0;
        PC  = 12'h000;
        repeat (3) @(negedge clk);
        chk("rst_ir", IR, 16'h0000);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_mem_addr", mem_addr, 12'h000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_pc_en", pc_en, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait fetch
        PC = 12'h000;
        expect_fetch(16'h1234, 0, 16'h1234, 12'h000, 1'b0);
        en = 1'b1;
        @(negedge clk);
        chk("zw_req_rd", mem_rd, 1'b1);
        chk("zw_req_valid", ir_valid, 1'b0);
        chk("zw_busy", busy, 1'b1);
        wait_valid(1, lat);
        chk("zw_pc_en", pc_en, 1'b1);
        chk("zw_rd_low", mem_rd, 1'b0);
        en = 1'b0;
        @(negedge clk);
        chk("zw_valid_pulse", ir_valid, 1'b0);
        chk("zw_pc_en_pulse", pc_en, 1'b0);
        chk("zw_idle_busy", busy, 1'b0);

        // Three wait cycles, JMP, then the next fetch takes the new PC
        PC = 12'h010;
        expect_fetch(16'h8ABC, 3, 16'h8ABC, 12'h010, 1'b0);
        en = 1'b1;
        wait_valid(10, lat);
        chk("jmp_latency", lat, 32'd5);
        chk("jmp_pc_en", pc_en, 1'b1);
        PC = 12'h055;
        expect_fetch(16'h0042, 0, 16'h0042, 12'h055, 1'b0);
        @(negedge clk);
        chk("jmp_rd_len", last_len, 32'd4);
        chk("jmp_pc_en_single", pc_en, 1'b0);
        chk("jmp_next_rd", mem_rd, 1'b1);
        chk("jmp_next_addr", mem_addr, 12'h055);
        en = 1'b0;
        wait_valid(5, lat);
        @(negedge clk);
        chk("jmp_idle_busy", busy, 1'b0);

        // Conditional jump: LATCH then HOLD, two pc_en cycles, no request between
        PC = 12'h020;
        expect_fetch(16'h9010, 0, 16'h9010, 12'h020, 1'b0);
        en = 1'b1;
        wait_valid(5, lat);
        chk("jze_pc_en1", pc_en, 1'b1);
        en = 1'b0;
        @(negedge clk);
        chk("jze_pc_en2", pc_en, 1'b1);
        chk("jze_hold_rd", mem_rd, 1'b0);
        chk("jze_hold_valid", ir_valid, 1'b0);
        chk("jze_hold_busy", busy, 1'b1);
        @(negedge clk);
        chk("jze_pc_en_end", pc_en, 1'b0);
        chk("jze_idle_busy", busy, 1'b0);

        // Timeout: NOP loaded, sticky fault, fetching resumes
        PC = 12'h030;
        expect_fetch(16'hFFFF, -1, 16'h0000, 12'h030, 1'b1);
        en = 1'b1;
        wait_valid(40, lat);
        chk("to_latency", lat, 32'd17);
        chk("to_fault", fault, 1'b1);
        expect_fetch(16'h5A5A, 0, 16'h5A5A, 12'h030, 1'b1);
        @(negedge clk);
        chk("to_rd_len", last_len, 32'd16);
        chk("to_resume_rd", mem_rd, 1'b1);
        en = 1'b0;
        wait_valid(5, lat);
        @(negedge clk);
        chk("to_fault_sticky", fault, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("to_fault_cleared", fault, 1'b0);

        // Ack coincident with the timeout boundary: data wins, no fault
        PC = 12'h040;
        expect_fetch(16'hC3C3, 15, 16'hC3C3, 12'h040, 1'b0);
        en = 1'b1;
        wait_valid(40, lat);
        chk("edge_latency", lat, 32'd17);
        en = 1'b0;
        @(negedge clk);
        chk("edge_fault", fault, 1'b0);
        chk("edge_busy", busy, 1'b0);

        // Reset in the second WAIT cycle together with ack
        PC = 12'h050;
        mq.push_back('{16'hBEEF, 2});
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstw_in_wait", mem_ack, 1'b1);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_rd", mem_rd, 1'b0);
        chk("rstw_ir", IR, 16'h0000);
        chk("rstw_valid", ir_valid, 1'b0);
        chk("rstw_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("rstw_idle_rd", mem_rd, 1'b0);

        // en dropped during WAIT: the fetch completes once, then idle
        vc0 = valid_cnt;
        PC = 12'h060;
        expect_fetch(16'h1111, 3, 16'h1111, 12'h060, 1'b0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0;
        wait_valid(10, lat);
        chk("endrop_latency", lat, 32'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("endrop_busy", busy, 1'b0);
            chk("endrop_rd", mem_rd, 1'b0);
        end
        chk("endrop_valid_count", valid_cnt - vc0, 32'd1);

        chk("sb_drained", sb.size(), 32'd0);
        chk("mq_drained", mq.size(), 32'd0);
        chk("addr_stable", addr_bad, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
